// File: rtl/cpu_power_sequencer_if.sv
// cpu_power_sequencer_if: control/status bundle for the CPU power sequencer.
// master drives board status inputs, slave is the sequencer itself.
interface cpu_power_sequencer_if;
  logic       enable;
  logic       dsp_ready;
  logic       cpu_resetout;
  logic       pmic_pwron_drive;
  logic       cpu_reset_drive;
  logic       usbhub_reset_INV;
  logic       booted;
  logic       fault;
  logic [2:0] state;

  modport master (
    output enable,
    output dsp_ready,
    output cpu_resetout,
    input  pmic_pwron_drive,
    input  cpu_reset_drive,
    input  usbhub_reset_INV,
    input  booted,
    input  fault,
    input  state
  );

  modport slave (
    input  enable,
    input  dsp_ready,
    input  cpu_resetout,
    output pmic_pwron_drive,
    output cpu_reset_drive,
    output usbhub_reset_INV,
    output booted,
    output fault,
    output state
  );
endinterface

// File: rtl/cpu_power_sequencer.sv
// cpu_power_sequencer: PMIC power-on and CPU boot supervisor with retries.
// Moore FSM; every output is registered from the current state.
module cpu_power_sequencer #(
  parameter logic [23:0] SETTLE_CYCLES = 24'hC00000,
  parameter logic [23:0] PWRON_CYCLES  = 24'd2000000,
  parameter logic [23:0] BOOT_TIMEOUT  = 24'hFFFFFF,
  parameter logic [23:0] RESET_CYCLES  = 24'd40000,
  parameter logic [1:0]  MAX_RETRIES   = 2'd2
) (
  input logic sysclk,
  input logic reset,
  cpu_power_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_SETTLE    = 3'b001,
    S_PWRON     = 3'b010,
    S_WAIT_BOOT = 3'b011,
    S_RST       = 3'b100,
    S_RUN       = 3'b101,
    S_FAULT     = 3'b110
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [1:0]  retry_q, retry_d;
  logic [1:0]  deb_q, deb_d;
  logic        pwron_q, rstdrv_q, usb_q;
  logic        booted_q, fault_q;
  logic        mism, deb_pass, chg;

  // cpu_resetout is expected low while waiting for boot, high while running.
  always_comb begin
    mism = 1'b0;
    if (state_q == S_WAIT_BOOT) mism = bus.cpu_resetout;
    else if (state_q == S_RUN) mism = ~bus.cpu_resetout;
    deb_pass = mism && (deb_q == 2'd3);
  end

  // Next-state selection; enable low overrides every transition.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (bus.dsp_ready) state_d = S_SETTLE;
        S_SETTLE:
          if (!bus.dsp_ready) state_d = S_IDLE;
          else if (timer_q == SETTLE_CYCLES - 24'd1)
            state_d = S_PWRON;
        S_PWRON:
          if (timer_q == PWRON_CYCLES - 24'd1)
            state_d = S_WAIT_BOOT;
        S_WAIT_BOOT:
          if (deb_pass) state_d = S_RUN;
          else if (timer_q == BOOT_TIMEOUT - 24'd1)
            state_d = (retry_q < MAX_RETRIES) ? S_RST : S_FAULT;
        S_RST:
          if (timer_q == RESET_CYCLES - 24'd1)
            state_d = S_WAIT_BOOT;
        S_RUN:
          if (deb_pass) state_d = S_WAIT_BOOT;
        S_FAULT:
          state_d = S_FAULT;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  // Timer, debounce and retry bookkeeping around state changes.
  always_comb begin
    chg = (state_d != state_q);
    if (chg) timer_d = 24'd0;
    else if (&timer_q) timer_d = timer_q;
    else timer_d = timer_q + 24'd1;
    deb_d = (chg || !mism) ? 2'd0 : deb_q + 2'd1;
    retry_d = retry_q;
    if (chg && state_d == S_RST && retry_q != 2'd3)
      retry_d = retry_q + 2'd1;
    else if (chg && state_d == S_RUN)
      retry_d = 2'd0;
  end

  // State, counters and Moore outputs decoded from the registered state.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      timer_q  <= 24'd0;
      retry_q  <= 2'd0;
      deb_q    <= 2'd0;
      pwron_q  <= 1'b0;
      rstdrv_q <= 1'b0;
      usb_q    <= 1'b0;
      booted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      deb_q    <= deb_d;
      pwron_q  <= (state_q == S_PWRON);
      rstdrv_q <= (state_q == S_RST);
      usb_q    <= (state_q == S_RUN);
      booted_q <= (state_q == S_RUN);
      fault_q  <= (state_q == S_FAULT);
    end
  end

  assign bus.pmic_pwron_drive = pwron_q;
  assign bus.cpu_reset_drive  = rstdrv_q;
  assign bus.usbhub_reset_INV = usb_q;
  assign bus.booted           = booted_q;
  assign bus.fault            = fault_q;
  assign bus.state            = state_q;

endmodule

// File: tb/tb_cpu_power_sequencer.sv
// tb_cpu_power_sequencer: directed scenarios with a timed scoreboard.
// Expectations are queued with a due cycle and checked at the falling edge.
module tb_cpu_power_sequencer;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_SET  = 3'b001;
  localparam logic [2:0] ST_PWR  = 3'b010;
  localparam logic [2:0] ST_WB   = 3'b011;
  localparam logic [2:0] ST_RST  = 3'b100;
  localparam logic [2:0] ST_RUN  = 3'b101;
  localparam logic [2:0] ST_FLT  = 3'b110;

  localparam logic [7:0] M_ST  = 8'hE0;
  localparam logic [7:0] M_PW  = 8'h10;
  localparam logic [7:0] M_RD  = 8'h08;
  localparam logic [7:0] M_USB = 8'h04;
  localparam logic [7:0] M_BT  = 8'h02;
  localparam logic [7:0] M_FT  = 8'h01;
  localparam logic [7:0] M_ALL = 8'hFF;

  typedef struct {
    string      tag;
    int         due;
    logic [7:0] m;
    logic [7:0] v;
  } exp_t;

  logic sysclk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   pw_rise = 0, pw_hi = 0, rd_rise = 0, rd_hi = 0;
  logic pw_prev = 1'b0, rd_prev = 1'b0;
  int   s_pw_rise, s_pw_hi, s_rd_rise, s_rd_hi;
  logic [7:0] obs;

  cpu_power_sequencer_if bus ();

  cpu_power_sequencer #(
    .SETTLE_CYCLES(24'd8),
    .PWRON_CYCLES (24'd4),
    .BOOT_TIMEOUT (24'd16),
    .RESET_CYCLES (24'd3),
    .MAX_RETRIES  (2'd2)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  assign obs = {bus.state, bus.pmic_pwron_drive,
                bus.cpu_reset_drive, bus.usbhub_reset_INV,
                bus.booted, bus.fault};

  task automatic push(input int d, input string tag,
                      input logic [7:0] m, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.due = cyc + d;
    e.m   = m;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic drain();
    int i;
    logic [7:0] om, em;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        om = obs & q[i].m;
        em = q[i].v & q[i].m;
        checks++;
        assert (om === em) else begin
          failures++;
          $error("FAIL %s observed=%h expected=%h",
                 q[i].tag, om, em);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
    if (bus.pmic_pwron_drive === 1'b1) pw_hi++;
    if (bus.pmic_pwron_drive === 1'b1 && !pw_prev) pw_rise++;
    pw_prev = (bus.pmic_pwron_drive === 1'b1);
    if (bus.cpu_reset_drive === 1'b1) rd_hi++;
    if (bus.cpu_reset_drive === 1'b1 && !rd_prev) rd_rise++;
    rd_prev = (bus.cpu_reset_drive === 1'b1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sysclk);
      drain();
      @(posedge sysclk);
    end
    #1;
  endtask

  task automatic snap();
    s_pw_rise = pw_rise;
    s_pw_hi   = pw_hi;
    s_rd_rise = rd_rise;
    s_rd_hi   = rd_hi;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.dsp_ready = 1'b0;
    bus.cpu_resetout = 1'b0;
    tick(3);
    push(0, "reset_outs", M_ALL, 8'h00);

    // Nominal boot.
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.dsp_ready = 1'b1;
    snap();
    push(1, "A_settle", M_ST, {ST_SET, 5'b0});
    push(8, "A_settle_end", M_ST, {ST_SET, 5'b0});
    push(9, "A_pwron_st", M_ST | M_PW, {ST_PWR, 5'b0});
    for (int k = 10; k <= 13; k++)
      push(k, "A_pw_hi", M_PW, 8'h10);
    push(14, "A_pw_lo", M_ST | M_PW, {ST_WB, 5'b0});
    tick(18);
    chk("A_pw_pulses", pw_rise - s_pw_rise, 1);
    chk("A_pw_len", pw_hi - s_pw_hi, 4);
    bus.cpu_resetout = 1'b1;
    push(4, "A_run_st", M_ST | M_BT, {ST_RUN, 5'b00000});
    push(5, "A_booted", M_ST | M_BT | M_USB | M_FT,
         {ST_RUN, 5'b00110});
    tick(6);

    // Glitch rejection in RUN, then a real 4-cycle drop.
    bus.cpu_resetout = 1'b0;
    tick(3);
    bus.cpu_resetout = 1'b1;
    push(1, "E_glitch_run", M_ST | M_BT, {ST_RUN, 5'b00010});
    push(3, "E_glitch_run2", M_ST | M_BT, {ST_RUN, 5'b00010});
    tick(3);
    bus.cpu_resetout = 1'b0;
    snap();
    push(3, "E_still_run", M_ST | M_BT, {ST_RUN, 5'b00010});
    push(4, "E_waitboot", M_ST | M_BT, {ST_WB, 5'b00010});
    push(5, "E_unbooted", M_ST | M_BT | M_USB, {ST_WB, 5'b00000});

    // Boot never completes: two resets, then fault.
    push(20, "F_rst1_st", M_ST | M_RD, {ST_RST, 5'b00000});
    push(21, "F_rst1_drv", M_RD, 8'h08);
    push(23, "F_rst1_end", M_ST | M_RD, {ST_WB, 5'b01000});
    push(24, "F_rst1_off", M_RD, 8'h00);
    push(40, "F_rst2_drv", M_ST | M_RD, {ST_RST, 5'b01000});
    push(43, "F_rst2_off", M_RD, 8'h00);
    push(57, "F_wb_last", M_ST | M_FT, {ST_WB, 5'b00000});
    push(58, "F_fault_st", M_ST | M_FT, {ST_FLT, 5'b00000});
    push(59, "F_fault", M_ST | M_FT | M_BT, {ST_FLT, 5'b00001});
    tick(74);
    chk("F_rst_pulses", rd_rise - s_rd_rise, 2);
    chk("F_rst_len", rd_hi - s_rd_hi, 6);
    chk("F_no_pwron", pw_rise - s_pw_rise, 0);
    push(0, "F_hold", M_ST | M_FT, {ST_FLT, 5'b00001});
    bus.enable = 1'b0;
    push(1, "F_idle", M_ST, {ST_IDLE, 5'b0});
    push(2, "F_clear", M_ALL, 8'h00);
    tick(3);

    // Settle abort and restart.
    bus.enable = 1'b1;
    bus.dsp_ready = 1'b1;
    snap();
    tick(6);
    push(0, "S_mid", M_ST, {ST_SET, 5'b0});
    bus.dsp_ready = 1'b0;
    tick(1);
    bus.dsp_ready = 1'b1;
    push(0, "S_idle", M_ST, {ST_IDLE, 5'b0});
    push(1, "S_resettle", M_ST, {ST_SET, 5'b0});
    push(8, "S_settle_full", M_ST | M_PW, {ST_SET, 5'b0});
    push(9, "S_pwron", M_ST | M_PW, {ST_PWR, 5'b0});
    push(10, "S_pw_hi", M_PW, 8'h10);
    tick(9);
    chk("S_no_early_pw", pw_rise - s_pw_rise, 0);

    // Enable dropped mid-PWRON.
    tick(1);
    bus.enable = 1'b0;
    push(1, "X_idle", M_ST, {ST_IDLE, 5'b0});
    push(2, "X_pw_off", M_ST | M_PW, {ST_IDLE, 5'b0});
    push(3, "X_pw_off2", M_ST | M_PW, {ST_IDLE, 5'b0});
    tick(4);

    // Debounce pass on the timeout cycle, retries already used up.
    bus.enable = 1'b1;
    tick(14);
    bus.dsp_ready = 1'b0;
    push(0, "T_wb", M_ST, {ST_WB, 5'b0});
    tick(11);
    bus.cpu_resetout = 1'b1;
    push(3, "T_wb_last", M_ST, {ST_WB, 5'b0});
    push(4, "T_run", M_ST | M_FT, {ST_RUN, 5'b0});
    push(5, "T_booted", M_ST | M_BT | M_FT, {ST_RUN, 5'b00010});
    tick(6);

    // Drop to WAIT_BOOT, time out into RST, reset mid-RST.
    bus.cpu_resetout = 1'b0;
    push(4, "R_wb", M_ST, {ST_WB, 5'b0});
    push(20, "R_rst_st", M_ST | M_RD, {ST_RST, 5'b00000});
    push(21, "R_rst_drv", M_ST | M_RD, {ST_RST, 5'b01000});
    tick(21);
    reset = 1'b1;
    push(1, "R_reset", M_ALL, 8'h00);
    tick(2);
    push(0, "R_reset_hold", M_ALL, 8'h00);
    reset = 1'b0;
    tick(1);
    push(2, "R_idle", M_ALL, 8'h00);
    tick(4);

    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
